// File: rtl/vid_pkg.sv
// vid_pkg: shared BT.656 constants, XY bit layout and TRS FSM state encodings
package vid_pkg;
    localparam logic [7:0] TRS_FF = 8'hFF;
    localparam logic [7:0] TRS_00 = 8'h00;
    localparam int XY_ONE = 7;
    localparam int XY_F = 6;
    localparam int XY_V = 5;
    localparam int XY_H = 4;
    typedef enum logic [1:0] {ST_DATA, ST_FF, ST_Z1, ST_Z2} trs_st_t;
    // protection nibble {P3,P2,P1,P0} for a given F/V/H
    function automatic logic [3:0] xy_par(input logic f, input logic v, input logic h);
        return {v ^ h, f ^ h, f ^ v, f ^ v ^ h};
    endfunction
endpackage

// File: rtl/vid_bt656_xy_chk.sv
// vid_bt656_xy_chk: XY protection check; VID_BT656_ECC_EN adds single-bit correction of b6..b0
module vid_bt656_xy_chk
    import vid_pkg::*;
(
    input  logic [7:0] xy,
    output logic       valid,
    output logic       corr,
    output logic       f,
    output logic       v,
    output logic       h
);
    logic [3:0] syn;
    assign syn = xy[3:0] ^ xy_par(xy[XY_F], xy[XY_V], xy[XY_H]);
`ifdef VID_BT656_ECC_EN
    logic fix_f, fix_v, fix_h, fix_p;
    assign fix_f = syn == 4'b0111;
    assign fix_v = syn == 4'b1011;
    assign fix_h = syn == 4'b1101;
    assign fix_p = $onehot(syn);
    assign corr = xy[XY_ONE] & (fix_f | fix_v | fix_h | fix_p);
    assign valid = xy[XY_ONE] & ((syn == 4'b0000) | corr);
    assign f = xy[XY_F] ^ fix_f;
    assign v = xy[XY_V] ^ fix_v;
    assign h = xy[XY_H] ^ fix_h;
`else
    assign corr = 1'b0;
    assign valid = xy[XY_ONE] & (syn == 4'b0000);
    assign f = xy[XY_F];
    assign v = xy[XY_V];
    assign h = xy[XY_H];
`endif
endmodule

// File: rtl/vid_bt656_dec.sv
// vid_bt656_dec: BT.656 decoder -- TRS search, active-video extraction, line sanity and lock status
// Optional single-bit XY correction when VID_BT656_ECC_EN is defined.
module vid_bt656_dec
    import vid_pkg::*;
#(
    parameter int H_BYTES = 1440,
    parameter int LOCK_LINES = 4,
    parameter int ERR_W = 16
) (
    input  logic             vid_clk,
    input  logic             vid_rst_n,
    input  logic [7:0]       in_data,
    input  logic             in_err,
    output logic [7:0]       out_data,
    output logic             out_valid,
    output logic             out_sol,
    output logic             out_sof,
    output logic             out_field,
    output logic             stat_lock,
    output logic [ERR_W-1:0] stat_err_cnt,
    input  logic             stat_clr
);
    localparam int GW = $clog2(LOCK_LINES + 1);
    localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_LINES);
    trs_st_t state, state_nxt;
    logic xy_stb, xy_ok, xy_corr, xy_f, xy_v, xy_h;
    logic active, sol_pend, sof_pend, prev_v;
    logic [11:0] bcnt;
    logic [GW-1:0] good, good_nxt;
    logic is_ff, data_byte, line_end, good_line, len_err, xy_bad, full_err, err_evt, sav_act;

    vid_bt656_xy_chk u_xy (
        .xy(in_data),
        .valid(xy_ok),
        .corr(xy_corr),
        .f(xy_f),
        .v(xy_v),
        .h(xy_h)
    );

    always_ff @(posedge vid_clk or negedge vid_rst_n)
        if (!vid_rst_n) state <= ST_DATA;
        else state <= state_nxt;

    always_comb
        state_nxt = (state == ST_Z2) ? ST_DATA :
                    is_ff ? ST_FF :
                    (in_data != TRS_00) ? ST_DATA :
                    (state == ST_FF) ? ST_Z1 :
                    (state == ST_Z1) ? ST_Z2 : ST_DATA;

    always_comb
        xy_stb = state == ST_Z2;

    always_comb begin
        is_ff = in_data == TRS_FF;
        data_byte = active & ~is_ff;
        line_end = active & is_ff;
        good_line = line_end & (bcnt == 12'(H_BYTES));
        len_err = line_end & ~good_line;
        xy_bad = xy_stb & ~xy_ok;
        full_err = xy_bad | len_err | in_err;
        err_evt = full_err | (xy_stb & xy_corr);
        sav_act = xy_stb & xy_ok & ~xy_h & ~xy_v;
        good_nxt = full_err ? '0 : (good_line && good != GOOD_MAX) ? good + GW'(1) : good;
    end

    // a line opens only on a valid V=0 SAV and closes on the first FF that follows
    always_ff @(posedge vid_clk or negedge vid_rst_n)
        if (!vid_rst_n) begin
            active <= 1'b0;
            bcnt <= '0;
            sol_pend <= 1'b0;
            sof_pend <= 1'b0;
            prev_v <= 1'b1;
            good <= '0;
            out_data <= '0;
            out_valid <= 1'b0;
            out_sol <= 1'b0;
            out_sof <= 1'b0;
            out_field <= 1'b0;
            stat_lock <= 1'b0;
            stat_err_cnt <= '0;
        end else begin
            active <= sav_act ? 1'b1 : line_end ? 1'b0 : active;
            bcnt <= sav_act ? '0 : (data_byte && bcnt != '1) ? bcnt + 12'd1 : bcnt;
            sol_pend <= sav_act ? 1'b1 : data_byte ? 1'b0 : sol_pend;
            sof_pend <= sav_act ? prev_v : data_byte ? 1'b0 : sof_pend;
            prev_v <= (xy_stb && xy_ok) ? xy_v : prev_v;
            good <= good_nxt;
            out_data <= data_byte ? in_data : '0;
            out_valid <= data_byte;
            out_sol <= data_byte & sol_pend;
            out_sof <= data_byte & sof_pend;
            out_field <= sav_act ? xy_f : out_field;
            stat_lock <= good_nxt == GOOD_MAX;
            stat_err_cnt <= stat_clr ? '0 : (err_evt && stat_err_cnt != '1) ? stat_err_cnt + ERR_W'(1) : stat_err_cnt;
        end
endmodule
